led_pwm_driver: RTL



---
 rtl/led_pwm_driver.sv | 84 ++++++++
 1 files changed

// File: rtl/led_pwm_driver.sv
// PWM driver for RGB and basic LEDs sharing one 255-step period.
// Duty bytes are captured at each period start so a period never glitches.
module led_pwm_driver #(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4,
  parameter int parm_FCLK            = 40_000_000,
  parameter int parm_pwm_clk_div     = 40,
  localparam int c_color_value_upper = 8*parm_color_led_count-1,
  localparam int c_basic_value_upper = 8*parm_basic_led_count-1
) (
  input  logic                           i_clk,
  input  logic                           i_srst,
  input  logic [c_color_value_upper:0]   i_color_led_red_value,
  input  logic [c_color_value_upper:0]   i_color_led_green_value,
  input  logic [c_color_value_upper:0]   i_color_led_blue_value,
  input  logic [c_basic_value_upper:0]   i_basic_led_lumin_value,
  output logic [parm_color_led_count-1:0] eo_color_leds_r,
  output logic [parm_color_led_count-1:0] eo_color_leds_g,
  output logic [parm_color_led_count-1:0] eo_color_leds_b,
  output logic [parm_basic_led_count-1:0] eo_basic_leds_l,
  output logic                           o_period_start
);

  localparam int c_cc    = parm_color_led_count;
  localparam int c_bc    = parm_basic_led_count;
  localparam int c_nch   = 3*c_cc + c_bc;
  localparam int c_pre_w =
    (parm_pwm_clk_div > 1) ? $clog2(parm_pwm_clk_div) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last =
    c_pre_w'(parm_pwm_clk_div-1);

  if (parm_pwm_clk_div < 1 || parm_FCLK < 1) begin : g_bad_parm
    $error("led_pwm_driver: bad clock parameters");
  end

  logic [c_pre_w-1:0] s_pre;
  logic [7:0]         s_cnt;
  logic               s_step;
  logic               s_ps;
  logic [8*c_nch-1:0] s_in;
  logic [8*c_nch-1:0] s_shadow;
  logic [c_nch-1:0]   s_hit;
  logic [c_nch-1:0]   s_out;

  // Channel order: red, green, blue, basic (LSB first).
  assign s_in = {i_basic_led_lumin_value,
                 i_color_led_blue_value,
                 i_color_led_green_value,
                 i_color_led_red_value};

  assign s_step = (s_pre == c_pre_last);
  assign s_ps   = (s_pre == '0) && (s_cnt == 8'd0);

  for (genvar i = 0; i < c_nch; i++) begin : g_ch
    logic [7:0] eff;
    assign eff      = s_ps ? s_in[8*i +: 8] : s_shadow[8*i +: 8];
    assign s_hit[i] = (s_cnt < eff);
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      s_pre          <= '0;
      s_cnt          <= '0;
      s_shadow       <= '0;
      s_out          <= '0;
      o_period_start <= 1'b0;
    end else begin
      s_pre <= s_step ? '0 : s_pre + 1'b1;
      // Count stops at 254 so a full-scale byte stays high all period.
      if (s_step)
        s_cnt <= (s_cnt == 8'd254) ? 8'd0 : s_cnt + 8'd1;
      if (s_ps)
        s_shadow <= s_in;
      s_out          <= s_hit;
      o_period_start <= s_ps;
    end
  end

  assign eo_color_leds_r = s_out[c_cc-1:0];
  assign eo_color_leds_g = s_out[2*c_cc-1:c_cc];
  assign eo_color_leds_b = s_out[3*c_cc-1:2*c_cc];
  assign eo_basic_leds_l = s_out[c_nch-1:3*c_cc];

endmodule
